// File: rtl/cmp_pkg.sv
// Shared types for the serial magnitude comparator: FSM states and result codes.
package cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef logic [1:0] cmp_res_t;

    localparam cmp_res_t CMP_NONE = 2'b00;
    localparam cmp_res_t CMP_LT   = 2'b01;
    localparam cmp_res_t CMP_GT   = 2'b10;
    localparam cmp_res_t CMP_EQ   = 2'b11;

    // Fold a pair of slice flags into one result code; neither flag set means equal.
    function automatic cmp_res_t encode_res(input logic lt, input logic gt);
        if (lt) begin
            return CMP_LT;
        end
        if (gt) begin
            return CMP_GT;
        end
        return CMP_EQ;
    endfunction

endpackage

// File: rtl/slice_compare.sv
// Combinational STEP-bit unsigned comparator built from a MSB-first chain of 1-bit cells.
module slice_compare #(
    parameter int unsigned STEP = 1
) (
    input  logic [STEP-1:0] a,
    input  logic [STEP-1:0] b,
    output logic            lt,
    output logic            gt,
    output logic            eq
);

    logic lt_acc;
    logic gt_acc;

    // Each iteration is one cell: the first differing bit from the top latches the decision.
    always_comb begin
        lt_acc = 1'b0;
        gt_acc = 1'b0;
        for (int k = STEP - 1; k >= 0; k--) begin
            {lt_acc, gt_acc} = {lt_acc | (~gt_acc & ~a[k] &  b[k]),
                                gt_acc | (~lt_acc &  a[k] & ~b[k])};
        end
    end

    assign lt = lt_acc;
    assign gt = gt_acc;
    assign eq = ~(lt_acc | gt_acc);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Sequential MSB-first magnitude comparator, STEP bits per clock with early exit.
// Optional two's-complement mode (signed_mode port) when SERIAL_CMP_SIGNED_EN is defined.
module serial_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [WIDTH-1:0]            a,
    input  logic [WIDTH-1:0]            b,
`ifdef SERIAL_CMP_SIGNED_EN
    input  logic                        signed_mode,
`endif
    output logic                        busy,
    output logic                        done,
    output logic                        lesser,
    output logic                        greater,
    output logic                        equal,
    output logic [$clog2(WIDTH/STEP):0] slices
);

    localparam int unsigned NUM_SLICES = WIDTH / STEP;
    localparam int unsigned SLW        = $clog2(NUM_SLICES) + 1;

    if (WIDTH < 2) begin : g_bad_width
        $error("serial_magnitude_comparator: WIDTH must be at least 2");
    end
    if ((STEP < 1) || (STEP > WIDTH) || ((WIDTH % STEP) != 0)) begin : g_bad_step
        $error("serial_magnitude_comparator: STEP must divide WIDTH");
    end

    state_e           state_q,   state_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic [SLW-1:0]   idx_q,     idx_d;
    logic [SLW-1:0]   cnt_q,     cnt_d;
    cmp_res_t         res_q,     res_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             lesser_q,  lesser_d;
    logic             greater_q, greater_d;
    logic             equal_q,   equal_d;
    logic [SLW-1:0]   slices_q,  slices_d;

    logic             sl_lt;
    logic             sl_gt;
    logic             sl_eq;
    logic             last_slice_c;
    logic [WIDTH-1:0] msb_flip_c;

    // Biasing the sign bit of both operands turns a signed compare into an unsigned one.
`ifdef SERIAL_CMP_SIGNED_EN
    assign msb_flip_c = {signed_mode, {(WIDTH-1){1'b0}}};
`else
    assign msb_flip_c = '0;
`endif

    // Operands shift left each step, so the active slice is always the top STEP bits.
    slice_compare #(
        .STEP (STEP)
    ) u_slice_compare (
        .a  (a_q[WIDTH-1 -: STEP]),
        .b  (b_q[WIDTH-1 -: STEP]),
        .lt (sl_lt),
        .gt (sl_gt),
        .eq (sl_eq)
    );

    assign last_slice_c = (idx_q == SLW'(NUM_SLICES - 1));

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        lesser_d  = lesser_q;
        greater_d = greater_q;
        equal_d   = equal_q;
        slices_d  = slices_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !busy_q) begin
                    a_d     = a ^ msb_flip_c;
                    b_d     = b ^ msb_flip_c;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!sl_eq || last_slice_c) begin
                    res_d   = encode_res(sl_lt, sl_gt);
                    cnt_d   = idx_q + SLW'(1);
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + SLW'(1);
                    a_d   = a_q << STEP;
                    b_d   = b_q << STEP;
                end
            end
            ST_DONE: begin
                // Results become visible together with the done pulse.
                lesser_d  = (res_q == CMP_LT);
                greater_d = (res_q == CMP_GT);
                equal_d   = (res_q == CMP_EQ);
                slices_d  = cnt_q;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE) || (state_q == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            res_q     <= CMP_NONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            lesser_q  <= 1'b0;
            greater_q <= 1'b0;
            equal_q   <= 1'b0;
            slices_q  <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            lesser_q  <= lesser_d;
            greater_q <= greater_d;
            equal_q   <= equal_d;
            slices_q  <= slices_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign lesser  = lesser_q;
    assign greater = greater_q;
    assign equal   = equal_q;
    assign slices  = slices_q;

endmodule
